// File: rtl/fixed_point_pkg.sv
// Shared fixed-point types and the W_ACC -> W range clamp used by the accumulator and future multiplier.
// Combinational helpers only; no latency, no flow control.
package fixed_point_pkg;

   localparam int FXP_MAX_W = 64;

   typedef enum logic {ACCUM, HOLD} acc_state_t;

   typedef struct packed {
      logic                 ovf;
      logic [FXP_MAX_W-1:0] dat;
   } fxp_sat_t;

   // sum arrives already extended to FXP_MAX_W from its w_acc-bit width
   function automatic fxp_sat_t fxp_saturate(input logic [FXP_MAX_W-1:0] sum,
                                             input int                   w_acc,
                                             input int                   w,
                                             input logic                 is_signed);
      fxp_sat_t             r;
      logic [FXP_MAX_W-1:0] max_v;
      logic [FXP_MAX_W-1:0] min_v;
      logic                 neg;
      neg = is_signed & sum[w_acc-1];
      if (is_signed) begin
         max_v = (FXP_MAX_W'(1) << (w-1)) - FXP_MAX_W'(1);
         min_v = ~max_v;
      end else begin
         max_v = (FXP_MAX_W'(1) << w) - FXP_MAX_W'(1);
         min_v = '0;
      end
      r.ovf = neg ? ($signed(sum) < $signed(min_v)) : (sum > max_v);
      r.dat = r.ovf ? (neg ? min_v : max_v) : sum;
      return r;
   endfunction

endpackage

// File: rtl/fixed_point_saturate.sv
// W_ACC -> W result narrowing with overflow flag; clamps when FXP_ACC_SATURATE_EN is defined, wraps otherwise.
// Purely combinational, no handshake.
module fixed_point_saturate
   import fixed_point_pkg::*;
#(
   parameter int SIGN  = 1,
   parameter int W     = 33,
   parameter int W_ACC = 41
)(
   input  logic [W_ACC-1:0] sum_dat,
   output logic [W-1:0]     res_dat,
   output logic             res_ovf
);

   logic signed [W_ACC-1:0]     sum_s;
   logic signed [FXP_MAX_W-1:0] sum_sx;
   logic [FXP_MAX_W-1:0]        sum_ext;
   fxp_sat_t                    sat;
   logic                        unused_bits;

   always_comb begin
      sum_s   = sum_dat;
      sum_sx  = sum_s;
      sum_ext = (SIGN != 0) ? sum_sx : FXP_MAX_W'(sum_dat);
      sat     = fxp_saturate(sum_ext, W_ACC, W, SIGN != 0);
`ifdef FXP_ACC_SATURATE_EN
      res_dat = sat.dat[W-1:0];
`else
      res_dat = sum_ext[W-1:0];
`endif
      res_ovf = sat.ovf;
   end

   assign unused_bits = ^{sat.dat, sum_ext};

endmodule

// File: rtl/fixed_point_accumulator.sv
// Streaming Q(M.N) burst accumulator; result saturates when FXP_ACC_SATURATE_EN is defined, wraps otherwise.
// Latency: result valid the cycle after the last beat.
// Backpressure: in_ready_o drops while a result is held; it returns the cycle after out_ready_i accepts it.
module fixed_point_accumulator
   import fixed_point_pkg::*;
#(
   parameter  int SIGN       = 1,
   parameter  int Q_M        = 16,
   parameter  int Q_N        = 16,
   parameter  int GUARD_BITS = 8,
   parameter  int CNT_W      = 8,
   localparam int W          = SIGN + Q_M + Q_N,
   localparam int W_ACC      = W + GUARD_BITS
)(
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [W-1:0]     in_data_i,
   input  logic             in_last_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [W-1:0]     out_data_o,
   output logic [CNT_W-1:0] out_count_o,
   output logic             out_ovf_o
);

   acc_state_t       state;
   acc_state_t       state_nxt;
   logic             beat;
   logic             res_taken;
   logic [W_ACC-1:0] acc;
   logic [W_ACC-1:0] term_ext;
   logic [W_ACC-1:0] sum_nxt;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] count_nxt;
   logic [W-1:0]     res_dat;
   logic             res_ovf;

   assign term_ext  = {{GUARD_BITS{(SIGN != 0) & in_data_i[W-1]}}, in_data_i};
   assign sum_nxt   = acc + term_ext;
   assign count_nxt = (count == '1) ? count : count + CNT_W'(1);

   always_ff @(posedge clk_i) begin
      if (rst_i) state <= ACCUM;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      in_ready_o = 1'b0;
      beat       = 1'b0;
      res_taken  = 1'b0;
      case (state)
         ACCUM: begin
            in_ready_o = 1'b1;
            beat       = in_valid_i;
            if (beat && in_last_i) state_nxt = HOLD;
         end
         HOLD: begin
            res_taken = out_ready_i;
            if (out_ready_i) state_nxt = ACCUM;
         end
         default: state_nxt = ACCUM;
      endcase
   end

   // the final term is folded in combinationally so the result needs no extra cycle
   fixed_point_saturate #(
      .SIGN  (SIGN),
      .W     (W),
      .W_ACC (W_ACC)
   ) u_sat (
      .sum_dat (sum_nxt),
      .res_dat (res_dat),
      .res_ovf (res_ovf)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         acc         <= '0;
         count       <= '0;
         out_valid_o <= 1'b0;
         out_data_o  <= '0;
         out_count_o <= '0;
         out_ovf_o   <= 1'b0;
      end else if (beat && in_last_i) begin
         acc         <= '0;
         count       <= '0;
         out_valid_o <= 1'b1;
         out_data_o  <= res_dat;
         out_count_o <= count_nxt;
         out_ovf_o   <= res_ovf;
      end else if (beat) begin
         acc         <= sum_nxt;
         count       <= count_nxt;
      end else if (res_taken) begin
         out_valid_o <= 1'b0;
      end
   end

endmodule

// File: tb/tb_fixed_point_accumulator.sv
// Bench for fixed_point_accumulator: vector table, hand-written corner sequences and random bursts vs a reference model.
module tb_fixed_point_accumulator;

   localparam int SIGN       = 1;
   localparam int Q_M        = 16;
   localparam int Q_N        = 16;
   localparam int GUARD_BITS = 8;
   localparam int CNT_W      = 8;
   localparam int W          = SIGN + Q_M + Q_N;
   localparam int W_ACC      = W + GUARD_BITS;

   logic             clk_i = 1'b0;
   logic             rst_i;
   logic             in_valid_i;
   logic             in_ready_o;
   logic [W-1:0]     in_data_i;
   logic             in_last_i;
   logic             out_valid_o;
   logic             out_ready_i;
   logic [W-1:0]     out_data_o;
   logic [CNT_W-1:0] out_count_o;
   logic             out_ovf_o;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk_i = ~clk_i;

   fixed_point_accumulator #(
      .SIGN(SIGN), .Q_M(Q_M), .Q_N(Q_N), .GUARD_BITS(GUARD_BITS), .CNT_W(CNT_W)
   ) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .in_valid_i  (in_valid_i),
      .in_ready_o  (in_ready_o),
      .in_data_i   (in_data_i),
      .in_last_i   (in_last_i),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i),
      .out_data_o  (out_data_o),
      .out_count_o (out_count_o),
      .out_ovf_o   (out_ovf_o)
   );

   typedef struct packed {
      int     n;
      longint t0;
      longint t1;
      longint t2;
      longint d;
      int     c;
      bit     o;
   } vec_t;

   localparam longint MAXP = (longint'(1) <<< (W-1)) - 1;
   localparam longint MINN = -(longint'(1) <<< (W-1));

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   // Reference: exact integer sum wrapped to the accumulator width, then range-checked against W bits.
   function automatic void model(input longint q[$], output longint d, output int c, output bit o);
      longint s = 0;
      foreach (q[i]) begin
         s = s + q[i];
         s = (s <<< (64 - W_ACC)) >>> (64 - W_ACC);
      end
      o = (s > MAXP) || (s < MINN);
`ifdef FXP_ACC_SATURATE_EN
      d = !o ? s : ((s < 0) ? MINN : MAXP);
`else
      d = s;
`endif
      c = (q.size() > ((1 << CNT_W) - 1)) ? ((1 << CNT_W) - 1) : q.size();
   endfunction

   // Starts and ends just after a rising edge.
   task automatic run_burst(input longint q[$], input int stall, input bit offer,
                            input longint exp_d, input int exp_c, input bit exp_o, input string tag);
      logic [W-1:0] ed;
      longint       t;
      int           waited;
      ed = exp_d[W-1:0];
      for (int i = 0; i < q.size(); i++) begin
         t          = q[i];
         in_valid_i = 1'b1;
         in_data_i  = t[W-1:0];
         in_last_i  = (i == q.size() - 1);
         @(negedge clk_i);
         waited = 0;
         while (!in_ready_o && waited < 50) begin
            @(negedge clk_i);
            waited++;
         end
         chk({tag, "_in_ready"}, 64'(in_ready_o), 64'(1));
         @(posedge clk_i);
         #1;
      end
      in_valid_i = 1'b0;
      in_last_i  = 1'b0;
      @(negedge clk_i);
      chk({tag, "_out_valid"}, 64'(out_valid_o), 64'(1));
      chk({tag, "_data"},      64'(out_data_o),  64'(ed));
      chk({tag, "_count"},     64'(out_count_o), 64'(exp_c));
      chk({tag, "_ovf"},       64'(out_ovf_o),   64'(exp_o));
      chk({tag, "_hold_rdy"},  64'(in_ready_o),  64'(0));
      if (offer) begin
         in_valid_i = 1'b1;
         in_data_i  = W'(999);
         in_last_i  = 1'b1;
      end
      for (int k = 0; k < stall; k++) begin
         @(negedge clk_i);
         chk({tag, "_stall_valid"}, 64'(out_valid_o), 64'(1));
         chk({tag, "_stall_data"},  64'(out_data_o),  64'(ed));
         chk({tag, "_stall_count"}, 64'(out_count_o), 64'(exp_c));
         chk({tag, "_stall_rdy"},   64'(in_ready_o),  64'(0));
      end
      out_ready_i = 1'b1;
      @(posedge clk_i);
      #1;
      out_ready_i = 1'b0;
      in_valid_i  = 1'b0;
      in_last_i   = 1'b0;
      @(negedge clk_i);
      chk({tag, "_released"}, 64'(out_valid_o), 64'(0));
      @(posedge clk_i);
      #1;
   endtask

   vec_t   tbl [8];
   longint q[$];
   longint ed;
   int     ec;
   bit     eo;

   initial begin
      tbl[0] = '{2, 123, 146, 0, 269, 2, 1'b0};
      tbl[1] = '{3, -123, 146, -146, -123, 3, 1'b0};
      tbl[2] = '{1, 0, 0, 0, 0, 1, 1'b0};
      tbl[3] = '{2, 64'h7FFF_FFFF, 64'h7FFF_FFFF, 0, 64'hFFFF_FFFE, 2, 1'b0};
      tbl[6] = '{1, MAXP, 0, 0, MAXP, 1, 1'b0};
`ifdef FXP_ACC_SATURATE_EN
      tbl[4] = '{2, MAXP, MAXP, 0, MAXP, 2, 1'b1};
      tbl[5] = '{2, MINN, MINN, 0, MINN, 2, 1'b1};
      tbl[7] = '{2, MINN, -1, 0, MINN, 2, 1'b1};
`else
      tbl[4] = '{2, MAXP, MAXP, 0, 64'h1_FFFF_FFFE, 2, 1'b1};
      tbl[5] = '{2, MINN, MINN, 0, 0, 2, 1'b1};
      tbl[7] = '{2, MINN, -1, 0, 64'h0_FFFF_FFFF, 2, 1'b1};
`endif

      rst_i       = 1'b1;
      in_valid_i  = 1'b0;
      in_data_i   = '0;
      in_last_i   = 1'b0;
      out_ready_i = 1'b0;
      repeat (3) @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      @(negedge clk_i);
      chk("rst_out_valid", 64'(out_valid_o), 64'(0));
      chk("rst_out_data",  64'(out_data_o),  64'(0));
      chk("rst_out_count", 64'(out_count_o), 64'(0));
      chk("rst_out_ovf",   64'(out_ovf_o),   64'(0));
      chk("rst_in_ready",  64'(in_ready_o),  64'(1));
      @(posedge clk_i);
      #1;

      for (int i = 0; i < 8; i++) begin
         q = {};
         q.push_back(tbl[i].t0);
         if (tbl[i].n > 1) q.push_back(tbl[i].t1);
         if (tbl[i].n > 2) q.push_back(tbl[i].t2);
         run_burst(q, i % 3, 1'b0, tbl[i].d, tbl[i].c, tbl[i].o, $sformatf("vec%0d", i));
      end

      // 5-cycle stall with a term offered the whole time; it must not be consumed
      q = {};
      q.push_back(40);
      q.push_back(2);
      run_burst(q, 5, 1'b1, 42, 2, 1'b0, "stall");
      q = {};
      q.push_back(5);
      run_burst(q, 0, 1'b0, 5, 1, 1'b0, "after_stall");

      // reset mid-burst discards the partial sum
      in_valid_i = 1'b1; in_last_i = 1'b0; in_data_i = W'(5);
      @(posedge clk_i); #1;
      in_data_i = W'(7);
      @(posedge clk_i); #1;
      in_valid_i = 1'b0;
      rst_i = 1'b1;
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      q = {};
      q.push_back(1);
      run_burst(q, 0, 1'b0, 1, 1, 1'b0, "rst_mid");

      // reset while a result is held drops it
      in_valid_i = 1'b1; in_last_i = 1'b1; in_data_i = W'(9);
      @(posedge clk_i); #1;
      in_valid_i = 1'b0; in_last_i = 1'b0;
      @(negedge clk_i);
      chk("rst_hold_pre_valid", 64'(out_valid_o), 64'(1));
      rst_i = 1'b1;
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      @(negedge clk_i);
      chk("rst_hold_valid", 64'(out_valid_o), 64'(0));
      chk("rst_hold_data",  64'(out_data_o),  64'(0));
      chk("rst_hold_rdy",   64'(in_ready_o),  64'(1));
      @(posedge clk_i); #1;

      // 301 terms: counter saturates, sum does not
      q = {};
      for (int i = 0; i < 301; i++) q.push_back(1);
      run_burst(q, 1, 1'b0, 301, 255, 1'b0, "cnt_sat");

      for (int r = 0; r < 25; r++) begin
         int     len;
         longint t;
         len = $urandom_range(1, 6);
         q = {};
         for (int i = 0; i < len; i++) begin
            if ($urandom_range(0, 3) == 0) begin
               t = {$urandom(), $urandom()};
               t = (t <<< (64 - W)) >>> (64 - W);
            end else begin
               t = longint'($urandom_range(0, 2000)) - 1000;
            end
            q.push_back(t);
         end
         model(q, ed, ec, eo);
         run_burst(q, $urandom_range(0, 3), 1'b0, ed, ec, eo, $sformatf("rnd%0d", r));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
